// File: rtl/uart_rx_queue.sv
// 8N1 UART receiver feeding a first-word-fall-through byte queue.
// Reports overrun and framing errors as single-cycle pulses.
`timescale 1ns/1ps
module uart_rx_queue #(
    parameter int SYS_CLK_FREQ   = 12000000,
    parameter int BAUD_RATE      = 115200,
    parameter int MSG_QUEUE_SIZE = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rx,
    input  logic                                rd,
    output logic [7:0]                          msg,
    output logic                                empty,
    output logic                                full,
    output logic [$clog2(MSG_QUEUE_SIZE+1)-1:0] count,
    output logic                                overrun,
    output logic                                frame_err
);
    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int CYC_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(MSG_QUEUE_SIZE);
    localparam int CNT_W        = $clog2(MSG_QUEUE_SIZE + 1);
    localparam logic [CYC_W-1:0] HALF_END = CYC_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CYC_W-1:0] BIT_END  = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(MSG_QUEUE_SIZE);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         msg_q, msg_d;
    logic               overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic [7:0]         mem_q [MSG_QUEUE_SIZE];
    logic               sample_s, push_s, stop_low_s, pop_s, wr_en_s;

    // State register and all resettable datapath flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            cyc_q       <= {CYC_W{1'b0}};
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= CNT_ZERO;
            msg_q       <= 8'h00;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            msg_q       <= msg_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Queue storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= shift_q;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) state_d = ST_START;
                else         state_d = ST_IDLE;
            end
            ST_START: begin
                if (cyc_q == HALF_END) state_d = rx_s_q ? ST_IDLE : ST_DATA;
                else                   state_d = ST_START;
            end
            ST_DATA: begin
                if (cyc_q == BIT_END && bit_q == 3'd7) state_d = ST_STOP;
                else                                   state_d = ST_DATA;
            end
            ST_STOP: begin
                if (cyc_q == BIT_END) state_d = rx_s_q ? ST_IDLE : ST_WAIT_HIGH;
                else                  state_d = ST_STOP;
            end
            ST_WAIT_HIGH: begin
                if (rx_s_q) state_d = ST_IDLE;
                else        state_d = ST_WAIT_HIGH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: mid-bit sample strobes
    always_comb begin
        sample_s   = 1'b0;
        push_s     = 1'b0;
        stop_low_s = 1'b0;
        case (state_q)
            ST_DATA: sample_s = (cyc_q == BIT_END);
            ST_STOP: begin
                push_s     = (cyc_q == BIT_END) && rx_s_q;
                stop_low_s = (cyc_q == BIT_END) && !rx_s_q;
            end
            default: sample_s = 1'b0;
        endcase
    end

    // Synchronizer, bit timing and shift register
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        shift_d   = shift_q;
        if (state_d != state_q || state_q == ST_IDLE || state_q == ST_WAIT_HIGH
            || cyc_q == BIT_END) begin
            cyc_d = {CYC_W{1'b0}};
        end else begin
            cyc_d = cyc_q + CYC_W'(1);
        end
        if (state_q == ST_IDLE) begin
            bit_d = 3'd0;
        end else if (sample_s) begin
            bit_d = bit_q + 3'd1;
        end else begin
            bit_d = bit_q;
        end
        if (sample_s) begin
            shift_d[bit_q] = rx_s_q;
        end else begin
            shift_d = shift_q;
        end
    end

    // Queue control; a pop on the same cycle frees room for a push into a full queue
    always_comb begin
        pop_s       = rd && (count_q != CNT_ZERO);
        wr_en_s     = push_s && ((count_q != DEPTH) || pop_s);
        overrun_d   = push_s && !wr_en_s;
        frame_err_d = stop_low_s;
        wr_ptr_d    = wr_en_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop_s   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // Head lookahead: the byte being written is not in memory yet
        if (count_d == CNT_ZERO) begin
            msg_d = 8'h00;
        end else if (wr_en_s && rd_ptr_d == wr_ptr_q) begin
            msg_d = shift_q;
        end else begin
            msg_d = mem_q[rd_ptr_d];
        end
    end

    assign msg       = msg_q;
    assign count     = count_q;
    assign empty     = (count_q == CNT_ZERO);
    assign full      = (count_q == DEPTH);
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx_queue.sv
// Scoreboard bench for uart_rx_queue: stimulus queues expected bytes,
// a negedge monitor checks every accepted read and counts error pulses.
`timescale 1ns/1ps
module tb_uart_rx_queue;
    localparam int QS = 4;
    localparam int CW = $clog2(QS + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b1;
    logic          rd = 1'b0;
    logic [7:0]    msg;
    logic          empty, full, overrun, frame_err;
    logic [CW-1:0] count;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ovr_seen = 0;
    int         fe_seen  = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    uart_rx_queue #(
        .SYS_CLK_FREQ(16), .BAUD_RATE(4), .MSG_QUEUE_SIZE(QS)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .rd(rd), .msg(msg), .empty(empty),
        .full(full), .count(count), .overrun(overrun), .frame_err(frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: invariants, pulse counting and read-data scoreboard
    always @(negedge clk) begin
        if (reset) begin
            check("empty_full_exclusive", 32'(empty & full), 32'd0);
            if (empty) check("msg_zero_when_empty", 32'(msg), 32'h00);
            if (overrun) ovr_seen++;
            if (frame_err) fe_seen++;
            if (rd && !empty) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_read: got 0x%0h, expected no data", msg);
                end else begin
                    check("read_data", 32'(msg), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; returns in the DUT's stop-sample cycle
    task automatic send_bits(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        step(4);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(4);
        end
        rx = stop_bit;
        step(4);
    endtask

    task automatic send(input logic [7:0] b, input logic stored);
        if (stored) sb.push_back(b);
        send_bits(b, 1'b1);
        rx = 1'b1;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        step(1);
        rd = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ovr0, fe0;
        #1 reset = 1'b0;
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_msg", 32'(msg), 32'h00);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        step(3);
        reset = 1'b1;
        step(4);

        // Read on empty queue is ignored
        pulse_rd();
        check("rd_empty_count", 32'(count), 32'd0);
        check("rd_empty_empty", 32'(empty), 32'd1);

        // Single frame latency and pop
        send(8'hA5, 1'b1);
        check("a5_before_push", 32'(empty), 32'd1);
        step(1);
        check("a5_empty", 32'(empty), 32'd0);
        check("a5_count", 32'(count), 32'd1);
        check("a5_msg", 32'(msg), 32'hA5);
        step(3);
        pulse_rd();
        check("a5_pop_empty", 32'(empty), 32'd1);
        check("a5_pop_msg", 32'(msg), 32'h00);
        step(2);

        // Fill to full, then overrun on the fifth frame
        ovr0 = ovr_seen;
        fe0  = fe_seen;
        for (int i = 0; i < 4; i++) begin
            send(8'(i), 1'b1);
            step(2);
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd4);
        send(8'h04, 1'b0);
        step(3);
        check("ovr_pulses", 32'(ovr_seen - ovr0), 32'd1);
        check("ovr_count", 32'(count), 32'd4);
        check("ovr_head", 32'(msg), 32'h00);
        check("ovr_no_fe", 32'(fe_seen - fe0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            pulse_rd();
            step(1);
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_full", 32'(full), 32'd0);

        // Short glitch on the line is rejected
        fe0 = fe_seen;
        rx = 1'b0;
        step(1);
        rx = 1'b1;
        step(12);
        check("glitch_count", 32'(count), 32'd0);
        check("glitch_fe", 32'(fe_seen - fe0), 32'd0);
        send(8'h5A, 1'b1);
        step(1);
        check("after_glitch_msg", 32'(msg), 32'h5A);
        check("after_glitch_count", 32'(count), 32'd1);
        pulse_rd();
        step(2);

        // Framing error with held-low line
        fe0 = fe_seen;
        send_bits(8'h55, 1'b0);
        step(20);
        rx = 1'b1;
        step(4);
        check("fe_pulses", 32'(fe_seen - fe0), 32'd1);
        check("fe_no_push", 32'(empty), 32'd1);
        send(8'h3C, 1'b1);
        step(2);
        check("after_fe_msg", 32'(msg), 32'h3C);
        check("after_fe_count", 32'(count), 32'd1);
        check("fe_single", 32'(fe_seen - fe0), 32'd1);
        pulse_rd();
        step(2);

        // Simultaneous pop and push while full, across pointer wrap
        for (int i = 0; i < 4; i++) begin
            send(8'(8'h10 + i), 1'b1);
            step(2);
        end
        check("wrap_full", 32'(full), 32'd1);
        ovr0 = ovr_seen;
        send(8'h14, 1'b1);
        rd = 1'b1;
        step(1);
        rd = 1'b0;
        check("wrap_count", 32'(count), 32'd4);
        check("wrap_head", 32'(msg), 32'h11);
        step(2);
        check("wrap_no_ovr", 32'(ovr_seen - ovr0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            pulse_rd();
            step(1);
        end
        check("wrap_drained", 32'(empty), 32'd1);

        // Asynchronous reset mid-frame with a byte already queued
        send(8'h99, 1'b1);
        step(2);
        fork
            send_bits(8'h77, 1'b1);
            begin
                step(20);
                reset = 1'b0;
                #2;
                check("mid_rst_empty", 32'(empty), 32'd1);
                check("mid_rst_count", 32'(count), 32'd0);
                check("mid_rst_full", 32'(full), 32'd0);
                check("mid_rst_msg", 32'(msg), 32'h00);
                check("mid_rst_overrun", 32'(overrun), 32'd0);
                check("mid_rst_frame_err", 32'(frame_err), 32'd0);
                sb.delete();
            end
        join
        rx = 1'b1;
        step(3);
        reset = 1'b1;
        step(4);
        send(8'h81, 1'b1);
        step(1);
        check("post_rst_msg", 32'(msg), 32'h81);
        check("post_rst_count", 32'(count), 32'd1);
        pulse_rd();
        step(2);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
